// File: rtl/pattern_history_table_pkg.sv
// Purpose : shared types for the local branch predictor (counter encodings, in-flight entry, FSM states).
// Latency : n/a (package only).
// Backpressure: n/a.
package bp_pkg;

    localparam int PHT_HISTORY_LEN = 10;
    localparam int PHT_INDEX_LEN   = 7;

    // 2-bit saturating counter encodings
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        IDLE     = 1'b0,
        ROLLBACK = 1'b1
    } state_t;

    // One in-flight prediction: the PC index, the pre-shift history snapshot
    // and the direction that was predicted for it.
    typedef struct packed {
        logic [PHT_INDEX_LEN-1:0]   pc;
        logic [PHT_HISTORY_LEN-1:0] history;
        logic                       pred;
    } entry_t;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pattern_history_table_fifo.sv
// Purpose : circular buffer of in-flight predictions with push/pop/clear and an indexed read port.
// Latency : push/pop take effect at the next clock edge; head and indexed reads are combinational.
// Backpressure: caller must not push when full or pop when empty; full/empty exported for gating.
// Ports   : clk/reset (sync, active-high); clear empties the buffer; push/push_entry write the tail;
//           pop drops the head; head_entry/head_idx/tail_idx expose pointer state; rd_idx/rd_entry
//           read an arbitrary slot.
module inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  entry_t        push_entry,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output entry_t        head_entry,
    output logic [AW-1:0] head_idx,
    output logic [AW-1:0] tail_idx,
    input  logic [AW-1:0] rd_idx,
    output entry_t        rd_entry
);

    entry_t      mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty      = (wptr == rptr);
    assign head_idx   = rptr[AW-1:0];
    assign tail_idx   = wptr[AW-1:0];
    assign head_entry = mem[rptr[AW-1:0]];
    assign rd_entry   = mem[rd_idx];

endmodule

// File: rtl/pattern_history_table.sv
// Purpose : second-level pattern history table of a local branch predictor, with mispredict rollback
//           of the upstream history table.
// Latency : prediction is combinational; mispredict pulses one cycle after detection; rollback takes
//           one cycle per entry in flight at detection.
// Backpressure: predict_ready drops when the in-flight FIFO is full or during rollback; resolve_ready
//           drops during rollback.
// Ports   : clk/reset (sync, active-high); predict_enable/pc_bits_read/history_read -> prediction,
//           predict_ready; resolve_valid/resolve_taken -> resolve_ready, mispredict;
//           rollback_enabled/pc_bits_write/history_write drive the history-table parallel load.
module pattern_history_table
    import bp_pkg::*;
#(
    parameter int HISTORY_LEN = PHT_HISTORY_LEN,   // entry_t widths come from the package
    parameter int INDEX_LEN   = PHT_INDEX_LEN,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   predict_enable,
    input  logic [INDEX_LEN-1:0]   pc_bits_read,
    input  logic [HISTORY_LEN-1:0] history_read,
    output logic                   prediction,
    output logic                   predict_ready,
    input  logic                   resolve_valid,
    input  logic                   resolve_taken,
    output logic                   resolve_ready,
    output logic                   mispredict,
    output logic                   rollback_enabled,
    output logic [INDEX_LEN-1:0]   pc_bits_write,
    output logic [HISTORY_LEN-1:0] history_write
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRIES = 2 ** HISTORY_LEN;

    logic [1:0]    ctr [ENTRIES];
    state_t        state;
    logic [AW-1:0] walk;
    logic          taken_q;     // outcome of the mispredicted branch, held for the walk

    logic          full, empty;
    entry_t        head_entry, rd_entry, push_entry;
    logic [AW-1:0] head_idx, tail_idx;
    logic          push_acc, res_acc, mis_det, pop, clear, walk_last;

    assign prediction    = ctr[history_read][1];
    assign predict_ready = !full && (state == IDLE);
    assign resolve_ready = (state == IDLE);

    assign push_acc   = predict_enable && predict_ready;
    assign res_acc    = (state == IDLE) && resolve_valid && !empty;
    assign mis_det    = res_acc && (head_entry.pred != resolve_taken);
    // A mispredicted head stays in place so the walk can finish on it.
    assign pop        = res_acc && !mis_det;
    assign walk_last  = (walk == head_idx);
    assign clear      = (state == ROLLBACK) && walk_last;
    assign push_entry = '{pc: pc_bits_read, history: history_read, pred: prediction};

    inflight_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .push       (push_acc),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head_entry (head_entry),
        .head_idx   (head_idx),
        .tail_idx   (tail_idx),
        .rd_idx     (walk),
        .rd_entry   (rd_entry)
    );

    // Counter array; a same-cycle read at the updated index still sees the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= WNT;
        end else if (res_acc) begin
            ctr[head_entry.history] <= ctr_update(ctr[head_entry.history], resolve_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            walk       <= '0;
            taken_q    <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            mispredict <= 1'b0;
            case (state)
                IDLE: begin
                    if (mis_det) begin
                        state      <= ROLLBACK;
                        // Newest entry: the slot being written now if a push coincides.
                        walk       <= push_acc ? tail_idx : tail_idx - AW'(1);
                        taken_q    <= resolve_taken;
                        mispredict <= 1'b1;
                    end
                end
                ROLLBACK: begin
                    if (walk_last) state <= IDLE;
                    else           walk  <= walk - AW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Youngest to oldest, so the oldest snapshot of a repeated PC lands last.
    // The head entry is restored with its resolved outcome shifted in at bit 0.
    always_comb begin
        rollback_enabled = 1'b0;
        pc_bits_write    = '0;
        history_write    = '0;
        if (state == ROLLBACK) begin
            rollback_enabled = 1'b1;
            if (walk_last) begin
                pc_bits_write = head_entry.pc;
                history_write = {head_entry.history[HISTORY_LEN-2:0], taken_q};
            end else begin
                pc_bits_write = rd_entry.pc;
                history_write = rd_entry.history;
            end
        end
    end

endmodule
